// File: rtl/simd_issue_wb_if.sv
// simd_issue_wb_if: instruction handshake, host load/debug, ALU and writeback bus
// between the issue/writeback engine (slave) and its surroundings (master).
interface simd_issue_wb_if;
   // instruction stream
   logic         instr_valid;
   logic [31:0]  instr;
   logic         instr_ready;
   // host register load and debug read
   logic         ld_en;
   logic [4:0]   ld_addr;
   logic [127:0] ld_data;
   logic [4:0]   rd_addr;
   logic [127:0] rd_data;
   // simd_alu connection
   logic [3:0]   alu_opcode;
   logic [127:0] alu_op1;
   logic [127:0] alu_op2;
   logic [127:0] alu_result;
   // writeback / status
   logic         wb_valid;
   logic [4:0]   wb_dest;
   logic [127:0] wb_data;
   logic         illegal;

   // engine side
   modport slave (
      input  instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr, alu_result,
      output instr_ready, rd_data, alu_opcode, alu_op1, alu_op2,
             wb_valid, wb_dest, wb_data, illegal
   );

   // fetch / host / ALU side
   modport master (
      output instr_valid, instr, ld_en, ld_addr, ld_data, rd_addr, alu_result,
      input  instr_ready, rd_data, alu_opcode, alu_op1, alu_op2,
             wb_valid, wb_dest, wb_data, illegal
   );
endinterface

// File: rtl/simd_issue_wb.sv
// simd_issue_wb: single-issue vector instruction engine. Reads two operands from a
// 32 x 128-bit register file, drives simd_alu for ALU_LAT clocks, then writes the
// result back. Optional build macro LANE_MASK_EN enables a per-lane write mask
// taken from instr[22:19].
module simd_issue_wb #(
   parameter int unsigned NREGS   = 32,
   parameter int unsigned ALU_LAT = 1,
   parameter int unsigned NUM_OPS = 13
) (
   input  logic             clk,
   input  logic             reset,
   simd_issue_wb_if.slave   bus
);

   localparam int unsigned DATA_W = 128;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned OPC_W  = 4;
   localparam int unsigned CNT_W  = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rf [NREGS];

   logic [OPC_W-1:0]    r_opcode;
   logic [DATA_W-1:0]   r_op1;
   logic [DATA_W-1:0]   r_op2;
   logic [ADDR_W-1:0]   r_dest;
   logic                r_instr_ready;
   logic                r_wb_valid;
   logic [ADDR_W-1:0]   r_wb_dest;
   logic [DATA_W-1:0]   r_wb_data;
   logic                r_illegal;
   logic [DATA_W-1:0]   r_rd_data;

   logic [OPC_W-1:0]    w_opcode;
   logic [ADDR_W-1:0]   w_src1;
   logic [ADDR_W-1:0]   w_src2;
   logic [ADDR_W-1:0]   w_dest;
   logic                w_legal;
   logic                w_accept;
   logic                w_drop;
   logic                w_wb_fire;
   logic [DATA_W-1:0]   w_wb_value;

   // instruction field decode
   assign w_opcode = bus.instr[18:15];
   assign w_src1   = bus.instr[14:10];
   assign w_src2   = bus.instr[9:5];
   assign w_dest   = bus.instr[4:0];
   assign w_legal  = (32'(w_opcode) < NUM_OPS);

`ifdef LANE_MASK_EN
   logic [3:0]          r_mask;
   logic [DATA_W-1:0]   w_lane_bits;
   logic                w_unused_instr;
   assign w_unused_instr = ^bus.instr[31:23];

   // expand the 4-bit lane mask (bit3 -> lane0 at [127:96]) to a bit mask
   assign w_lane_bits = {{32{r_mask[3]}}, {32{r_mask[2]}},
                         {32{r_mask[1]}}, {32{r_mask[0]}}};

   // merge new result lanes with the destination's current contents
   always_comb begin
      w_wb_value = (bus.alu_result & w_lane_bits) | (r_rf[r_dest] & ~w_lane_bits);
   end

   // lane mask is captured with the instruction it belongs to
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mask <= 4'd0;
      end else if (w_accept) begin
         r_mask <= bus.instr[22:19];
      end
   end
`else
   logic                w_unused_instr;
   assign w_unused_instr = ^bus.instr[31:19];

   // all lanes take the ALU result
   always_comb begin
      w_wb_value = bus.alu_result;
   end
`endif

   // next-state and control strobes
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_drop       = 1'b0;
      w_wb_fire    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.instr_valid) begin
               if (w_legal) begin
                  w_accept     = 1'b1;
                  w_next_state = S_EXEC;
               end else begin
                  w_drop       = 1'b1;
               end
            end
         end
         S_EXEC: begin
            if (r_cnt == CNT_W'(1)) begin
               w_next_state = S_WB;
            end
         end
         S_WB: begin
            w_wb_fire    = 1'b1;
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ALU latency counter, loaded on accept and counted down in EXEC
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= CNT_W'(ALU_LAT);
      end else if ((r_state == S_EXEC) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   // ready is registered from the next state so it is high in every IDLE cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_instr_ready <= 1'b1;
      end else begin
         r_instr_ready <= (w_next_state == S_IDLE);
      end
   end

   // operand capture at accept; illegal opcodes never reach the ALU
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_opcode <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_dest   <= '0;
      end else if (w_accept) begin
         r_opcode <= w_opcode;
         r_op1    <= r_rf[w_src1];
         r_op2    <= r_rf[w_src2];
         r_dest   <= w_dest;
      end
   end

   // writeback report and illegal pulse
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wb_valid <= 1'b0;
         r_wb_dest  <= '0;
         r_wb_data  <= '0;
         r_illegal  <= 1'b0;
      end else begin
         r_wb_valid <= w_wb_fire;
         r_illegal  <= w_drop;
         if (w_wb_fire) begin
            r_wb_dest <= r_dest;
            r_wb_data <= w_wb_value;
         end
      end
   end

   // register file: host load first so a same-edge writeback overrides it; R0 stays 0
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         if (bus.ld_en && (bus.ld_addr != '0)) begin
            r_rf[bus.ld_addr] <= bus.ld_data;
         end
         if (w_wb_fire && (r_dest != '0)) begin
            r_rf[r_dest] <= w_wb_value;
         end
      end
   end

   // debug read port, one cycle latency, sees pre-edge contents
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= r_rf[bus.rd_addr];
      end
   end

   assign bus.instr_ready = r_instr_ready;
   assign bus.alu_opcode  = r_opcode;
   assign bus.alu_op1     = r_op1;
   assign bus.alu_op2     = r_op2;
   assign bus.wb_valid    = r_wb_valid;
   assign bus.wb_dest     = r_wb_dest;
   assign bus.wb_data     = r_wb_data;
   assign bus.illegal     = r_illegal;
   assign bus.rd_data     = r_rd_data;

endmodule

// File: tb/tb_simd_issue_wb.sv
// tb_simd_issue_wb: directed vectors for simd_issue_wb with a small registered
// ADD/SUB ALU stub (one clock of latency). Inputs change and outputs are sampled
// on the falling edge.
module tb_simd_issue_wb;

   localparam int unsigned ALU_LAT = 1;
   localparam int          EXP_LAT = ALU_LAT + 1;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;

   simd_issue_wb_if bus ();

   simd_issue_wb #(.NREGS(32), .ALU_LAT(ALU_LAT), .NUM_OPS(13)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [127:0] lanes(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
      return {a, b, c, d};
   endfunction

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] s1,
                                      input logic [4:0] s2, input logic [4:0] d,
                                      input logic [3:0] mask);
      return {9'd0, mask, op, s1, s2, d};
   endfunction

   // ALU stub: lane-wise ADD(0)/SUB(1), registered once
   always @(posedge clk) begin
      case (bus.alu_opcode)
         4'd0: bus.alu_result <= {bus.alu_op1[127:96] + bus.alu_op2[127:96],
                                  bus.alu_op1[95:64]  + bus.alu_op2[95:64],
                                  bus.alu_op1[63:32]  + bus.alu_op2[63:32],
                                  bus.alu_op1[31:0]   + bus.alu_op2[31:0]};
         4'd1: bus.alu_result <= {bus.alu_op1[127:96] - bus.alu_op2[127:96],
                                  bus.alu_op1[95:64]  - bus.alu_op2[95:64],
                                  bus.alu_op1[63:32]  - bus.alu_op2[63:32],
                                  bus.alu_op1[31:0]   - bus.alu_op2[31:0]};
         default: bus.alu_result <= '0;
      endcase
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // host load, one strobe
   task automatic load(input logic [4:0] a, input logic [127:0] d);
      bus.ld_en   = 1'b1;
      bus.ld_addr = a;
      bus.ld_data = d;
      @(negedge clk);
      bus.ld_en   = 1'b0;
   endtask

   // debug read through the registered port
   task automatic readreg(input logic [4:0] a, output logic [127:0] d);
      bus.rd_addr = a;
      @(negedge clk);
      d = bus.rd_data;
   endtask

   // issue one instruction and wait (bounded) for its writeback; optional host load
   // strobe at cycle index ld_at after acceptance
   task automatic issue(input logic [31:0] ins, input int ld_at, input logic [4:0] la,
                        input logic [127:0] ldv, output int lat, output logic [127:0] d,
                        output logic [4:0] dst, output logic busy_ok);
      lat     = -1;
      d       = '0;
      dst     = '0;
      busy_ok = 1'b1;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bus.wb_valid) begin
            lat = k;
            d   = bus.wb_data;
            dst = bus.wb_dest;
            break;
         end
         if (bus.instr_ready) busy_ok = 1'b0;
         if (k == ld_at) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = la;
            bus.ld_data = ldv;
         end
         @(negedge clk);
         bus.ld_en = 1'b0;
      end
   endtask

   initial begin
      logic [127:0] rd;
      logic [127:0] wd;
      logic [127:0] exp_r8;
      logic [4:0]   wdst;
      logic         bok;
      logic         seen;
      int           lat;

      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.ld_en       = 1'b0;
      bus.ld_addr     = '0;
      bus.ld_data     = '0;
      bus.rd_addr     = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_ready",  128'(bus.instr_ready), 128'(1));
      check("rst_wbv",    128'(bus.wb_valid),    128'(0));
      check("rst_ill",    128'(bus.illegal),     128'(0));
      check("rst_opc",    128'(bus.alu_opcode),  128'(0));
      check("rst_op1",    bus.alu_op1,           '0);
      check("rst_wbdata", bus.wb_data,           '0);
      check("rst_rd",     bus.rd_data,           '0);
      reset = 1'b1;
      @(negedge clk);

      // operands
      load(5'd1, lanes(32'd20, 32'd15, 32'd10, 32'd5));
      load(5'd2, lanes(32'd12, 32'd9, 32'd6, 32'd3));
      readreg(5'd1, rd);
      check("ld_r1", rd, lanes(32'd20, 32'd15, 32'd10, 32'd5));

      // ADD R1,R2 -> R3
      issue(mk(4'd0, 5'd1, 5'd2, 5'd3, 4'hF), -1, 5'd0, '0, lat, wd, wdst, bok);
      check("add_lat",   128'(lat),  128'(EXP_LAT));
      check("add_data",  wd,         128'h00000020_00000018_00000010_00000008);
      check("add_dest",  128'(wdst), 128'(3));
      check("add_busy",  128'(bok),  128'(1));
      readreg(5'd3, rd);
      check("rd_r3", rd, 128'h00000020_00000018_00000010_00000008);

      // SUB R1,R2 -> R4 then back-to-back ADD R4,R2 -> R5 (RAW)
      issue(mk(4'd1, 5'd1, 5'd2, 5'd4, 4'hF), -1, 5'd0, '0, lat, wd, wdst, bok);
      check("sub_data",  wd, lanes(32'd8, 32'd6, 32'd4, 32'd2));
      check("sub_busy",  128'(bok), 128'(1));
      check("raw_ready", 128'(bus.instr_ready), 128'(1));
      issue(mk(4'd0, 5'd4, 5'd2, 5'd5, 4'hF), -1, 5'd0, '0, lat, wd, wdst, bok);
      check("raw_data",  wd, lanes(32'd20, 32'd15, 32'd10, 32'd5));
      check("raw_dest",  128'(wdst), 128'(5));
      readreg(5'd4, rd);
      check("rd_r4", rd, lanes(32'd8, 32'd6, 32'd4, 32'd2));
      readreg(5'd5, rd);
      check("rd_r5", rd, lanes(32'd20, 32'd15, 32'd10, 32'd5));

      // illegal opcode 0xD -> R6
      bus.instr       = mk(4'hD, 5'd1, 5'd2, 5'd6, 4'hF);
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("ill_pulse", 128'(bus.illegal), 128'(1));
      check("ill_ready", 128'(bus.instr_ready), 128'(1));
      seen = bus.wb_valid;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (k == 0) check("ill_once", 128'(bus.illegal), 128'(0));
         if (bus.wb_valid) seen = 1'b1;
      end
      check("ill_no_wb", 128'(seen), 128'(0));
      readreg(5'd6, rd);
      check("ill_r6", rd, '0);

      // ADD to R0: reported but discarded
      issue(mk(4'd0, 5'd1, 5'd2, 5'd0, 4'hF), -1, 5'd0, '0, lat, wd, wdst, bok);
      check("r0_lat",  128'(lat), 128'(EXP_LAT));
      check("r0_data", wd, lanes(32'd32, 32'd24, 32'd16, 32'd8));
      check("r0_dest", 128'(wdst), 128'(0));
      readreg(5'd0, rd);
      check("r0_read", rd, '0);

      // host load to R0 ignored
      load(5'd0, {128{1'b1}});
      readreg(5'd0, rd);
      check("r0_ld", rd, '0);

      // lane mask 1010 on ADD -> R8 preloaded {1,1,1,1}
`ifdef LANE_MASK_EN
      exp_r8 = lanes(32'd32, 32'd1, 32'd16, 32'd1);
`else
      exp_r8 = lanes(32'd32, 32'd24, 32'd16, 32'd8);
`endif
      load(5'd8, lanes(32'd1, 32'd1, 32'd1, 32'd1));
      issue(mk(4'd0, 5'd1, 5'd2, 5'd8, 4'b1010), -1, 5'd0, '0, lat, wd, wdst, bok);
      check("mask_wb", wd, exp_r8);
      readreg(5'd8, rd);
      check("mask_r8", rd, exp_r8);

      // host load and writeback on the same edge to R9: writeback wins
      issue(mk(4'd0, 5'd1, 5'd2, 5'd9, 4'hF), 1, 5'd9, {32{4'hA}}, lat, wd, wdst, bok);
      readreg(5'd9, rd);
      check("coll_r9", rd, lanes(32'd32, 32'd24, 32'd16, 32'd8));

      // reload of a source during EXEC does not disturb the in-flight op
      issue(mk(4'd0, 5'd1, 5'd2, 5'd10, 4'hF), 0, 5'd1, '0, lat, wd, wdst, bok);
      check("cap_data", wd, lanes(32'd32, 32'd24, 32'd16, 32'd8));
      readreg(5'd1, rd);
      check("cap_r1", rd, '0);
      load(5'd1, lanes(32'd20, 32'd15, 32'd10, 32'd5));

      // reset during EXEC of ADD -> R7
      bus.instr       = mk(4'd0, 5'd1, 5'd2, 5'd7, 4'hF);
      bus.instr_valid = 1'b1;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      check("mid_busy", 128'(bus.instr_ready), 128'(0));
      reset = 1'b0;
      @(negedge clk);
      check("mid_wbv",    128'(bus.wb_valid),   128'(0));
      check("mid_ready",  128'(bus.instr_ready), 128'(1));
      check("mid_op1",    bus.alu_op1,          '0);
      check("mid_wbdata", bus.wb_data,          '0);
      reset = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.wb_valid) seen = 1'b1;
      end
      check("mid_no_wb", 128'(seen), 128'(0));
      check("mid_ready2", 128'(bus.instr_ready), 128'(1));
      readreg(5'd7, rd);
      check("mid_r7", rd, '0);
      readreg(5'd1, rd);
      check("mid_r1", rd, '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
